// File: rtl/expr_char_emitter_if.sv
// Character stream channel: 8-bit ASCII byte with valid/ready handshake
// and a last-character qualifier.
interface expr_char_emitter_if;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/expr_char_emitter.sv
// expr_char_emitter: serialises a packed expression request (digits and
// '+'/'*' operators) into a byte-per-cycle ASCII stream "d (op d)*".
// Optional macro EXPR_EMIT_TERM_EN appends a final '=' terminator.
module expr_char_emitter #(
  parameter  int unsigned MAX_OPS = 8,
  localparam int unsigned NW      = $clog2(MAX_OPS + 1),
  localparam int unsigned OW      = (MAX_OPS > 1) ? MAX_OPS - 1 : 1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [NW-1:0]          nops,
  input  logic [4*MAX_OPS-1:0]   digits,
  input  logic [OW-1:0]          ops,
  output logic                   busy,
  output logic                   err,
  expr_char_emitter_if.master    ch
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIG,
    S_OPR
`ifdef EXPR_EMIT_TERM_EN
    , S_TRM
`endif
  } state_t;

  state_t               r_state, w_state;
  logic [NW-1:0]        r_k, w_k;
  logic [NW-1:0]        r_nops, w_nops;
  logic [4*MAX_OPS-1:0] r_digits, w_digits;
  logic [OW-1:0]        r_ops, w_ops;
  logic [7:0]           r_out, w_out;
  logic                 r_valid, w_valid;
  logic                 r_last, w_last;
  logic                 r_busy, w_busy;
  logic                 r_err, w_err;

  logic                 w_xfer;
  logic                 w_req_ok;
  logic [NW-1:0]        w_k1;
  logic [NW-1:0]        w_nops_m1;
  logic [3:0]           w_dig_nxt;
  logic                 w_op_cur;

  assign w_xfer    = r_valid & ch.out_ready;
  assign w_k1      = r_k + 1'b1;
  assign w_nops_m1 = r_nops - 1'b1;

  // Request validation: operand count in range, every used digit is decimal
  always_comb begin
    w_req_ok = (nops != '0) && (nops <= NW'(MAX_OPS));
    for (int unsigned i = 0; i < MAX_OPS; i++) begin
      if ((NW'(i) < nops) && (digits[4*i +: 4] > 4'd9)) w_req_ok = 1'b0;
    end
  end

  // Select the next operand digit and the current operator from the snapshot
  always_comb begin
    w_dig_nxt = '0;
    w_op_cur  = 1'b0;
    for (int unsigned i = 0; i < MAX_OPS; i++) begin
      if (NW'(i) == w_k1) w_dig_nxt = r_digits[4*i +: 4];
    end
    for (int unsigned i = 0; i < OW; i++) begin
      if (NW'(i) == r_k) w_op_cur = r_ops[i];
    end
  end

  // Next-state and registered-output computation; everything holds by default
  always_comb begin
    w_state  = r_state;
    w_k      = r_k;
    w_nops   = r_nops;
    w_digits = r_digits;
    w_ops    = r_ops;
    w_out    = r_out;
    w_valid  = r_valid;
    w_last   = r_last;
    w_busy   = r_busy;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_req_ok) begin
            w_nops   = nops;
            w_digits = digits;
            w_ops    = ops;
            w_k      = '0;
            w_state  = S_DIG;
            w_out    = 8'd48 + {4'd0, digits[3:0]};
            w_valid  = 1'b1;
            w_busy   = 1'b1;
`ifdef EXPR_EMIT_TERM_EN
            w_last   = 1'b0;
`else
            w_last   = (nops == NW'(1));
`endif
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_DIG: begin
        if (w_xfer) begin
          if (r_k < w_nops_m1) begin
            w_state = S_OPR;
            w_out   = w_op_cur ? 8'd42 : 8'd43;
            w_last  = 1'b0;
          end else begin
`ifdef EXPR_EMIT_TERM_EN
            w_state = S_TRM;
            w_out   = 8'd61;
            w_last  = 1'b1;
`else
            w_state = S_IDLE;
            w_valid = 1'b0;
            w_busy  = 1'b0;
            w_last  = 1'b0;
`endif
          end
        end
      end
      S_OPR: begin
        if (w_xfer) begin
          w_k     = w_k1;
          w_state = S_DIG;
          w_out   = 8'd48 + {4'd0, w_dig_nxt};
`ifdef EXPR_EMIT_TERM_EN
          w_last  = 1'b0;
`else
          w_last  = (w_k1 == w_nops_m1);
`endif
        end
      end
`ifdef EXPR_EMIT_TERM_EN
      S_TRM: begin
        if (w_xfer) begin
          w_state = S_IDLE;
          w_valid = 1'b0;
          w_busy  = 1'b0;
          w_last  = 1'b0;
        end
      end
`endif
      default: w_state = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_nops   <= '0;
      r_digits <= '0;
      r_ops    <= '0;
      r_out    <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_k      <= w_k;
      r_nops   <= w_nops;
      r_digits <= w_digits;
      r_ops    <= w_ops;
      r_out    <= w_out;
      r_valid  <= w_valid;
      r_last   <= w_last;
      r_busy   <= w_busy;
      r_err    <= w_err;
    end
  end

  assign ch.out       = r_out;
  assign ch.out_valid = r_valid;
  assign ch.out_last  = r_last;
  assign busy         = r_busy;
  assign err          = r_err;

endmodule
